// File: rtl/num_pkg.sv
// Shared MIX constants for the character/number conversion units.
// BYTE_W    : bits per MIX byte
// DIGITS    : bytes (decimal digits) held in rA:rX
// WORD_W    : width of a MIX word magnitude (5 bytes)
// IN_W      : width of the combined rA:rX register pair
// CHAR_ZERO : MIX character code for '0'
package num_pkg;

  localparam int BYTE_W    = 6;
  localparam int DIGITS    = 10;
  localparam int WORD_W    = 30;
  localparam int IN_W      = BYTE_W * DIGITS;
  localparam int CHAR_ZERO = 30;
  localparam int CNT_W     = 4;

  // Digit count in the width of the job counter, so compares stay width-matched.
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

  // Character code of a decimal digit 0..9.
  function automatic logic [BYTE_W-1:0] char_code(input logic [3:0] digit);
    return BYTE_W'(CHAR_ZERO) + BYTE_W'(digit);
  endfunction

endpackage

// File: rtl/num_mod10_6.sv
// Combinational byte -> decimal digit reduction (byte mod 10) for NUM.
// byte_i  : 6-bit MIX byte, any value 0..63
// digit_o : byte_i mod 10, always 0..9
// Character codes 30..39 map onto 0..9 naturally; non-digit bytes are folded
// by the same rule without any error indication.
module num_mod10_6
  import num_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic [3:0]        digit_o
);

  // 64-entry table grouped by result digit.
  always_comb begin
    digit_o = 4'd0;
    case (byte_i)
      6'd0,  6'd10, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60: digit_o = 4'd0;
      6'd1,  6'd11, 6'd21, 6'd31, 6'd41, 6'd51, 6'd61: digit_o = 4'd1;
      6'd2,  6'd12, 6'd22, 6'd32, 6'd42, 6'd52, 6'd62: digit_o = 4'd2;
      6'd3,  6'd13, 6'd23, 6'd33, 6'd43, 6'd53, 6'd63: digit_o = 4'd3;
      6'd4,  6'd14, 6'd24, 6'd34, 6'd44, 6'd54:        digit_o = 4'd4;
      6'd5,  6'd15, 6'd25, 6'd35, 6'd45, 6'd55:        digit_o = 4'd5;
      6'd6,  6'd16, 6'd26, 6'd36, 6'd46, 6'd56:        digit_o = 4'd6;
      6'd7,  6'd17, 6'd27, 6'd37, 6'd47, 6'd57:        digit_o = 4'd7;
      6'd8,  6'd18, 6'd28, 6'd38, 6'd48, 6'd58:        digit_o = 4'd8;
      6'd9,  6'd19, 6'd29, 6'd39, 6'd49, 6'd59:        digit_o = 4'd9;
      default:                                         digit_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/num.sv
// MIX NUM execution unit: converts the 10 bytes of rA:rX into a 30-bit
// binary magnitude, one decimal digit per clock, most significant byte first.
// clk   : system clock
// reset : synchronous active-high reset (overrides start)
// start : one-cycle pulse; samples in and (re)starts a conversion
// stop  : high for exactly one cycle when out is final
// in    : {rA,rX}; byte k = in[59-6k -: 6], k=0 is the most significant digit
// out   : running/final result, held after stop until the next start/reset
module num
  import num_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              stop,
  input  logic [IN_W-1:0]   in,
  output logic [WORD_W-1:0] out
);

  logic              run_q,   run_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IN_W-1:0]   sr_q,    sr_d;
  logic [WORD_W-1:0] acc_q,   acc_d;
  logic [3:0]        digit;

  // Digit of the current top byte of the shift register.
  num_mod10_6 u_mod10 (
    .byte_i  (sr_q[IN_W-1 -: BYTE_W]),
    .digit_o (digit)
  );

  assign stop = run_q && (count_q == DIGITS_C);
  assign out  = acc_q;

  always_comb begin
    run_d   = run_q;
    count_d = count_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    if (start) begin
      // A start while busy simply restarts; the aborted job never signals stop.
      run_d   = 1'b1;
      count_d = '0;
      sr_d    = in;
      acc_d   = '0;
    end else if (run_q) begin
      if (count_q < DIGITS_C) begin
        // acc*10 + d as two shifts and adds; truncation gives the mod 2^30 wrap.
        acc_d   = (acc_q << 3) + (acc_q << 1) + WORD_W'(digit);
        sr_d    = sr_q << BYTE_W;
        count_d = count_q + 1'b1;
      end else begin
        // Edge after stop (or an impossible count > 10): go idle, keep acc.
        run_d   = 1'b0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= 1'b0;
      count_q <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
    end else begin
      run_q   <= run_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_num.sv
module tb_num;
  import num_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop;
  logic [59:0] in_v = '0;
  logic [29:0] out_v;

  int checks = 0;
  int failures = 0;
  int stop_seen = 0;

  num dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .in    (in_v),
    .out   (out_v)
  );

  always #5 clk = ~clk;

  // Every stop cycle contains one falling edge, so this counts stop pulses.
  always @(negedge clk) if (stop) stop_seen++;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal accumulation of (byte mod 10), reduced mod 2^30.
  function automatic longint ref_num(input logic [59:0] v);
    longint acc = 0;
    for (int k = 0; k < 10; k++) begin
      int b;
      b = int'(v[59-6*k -: 6]);
      acc = (acc * 10 + (b % 10)) % (64'd1 << 30);
    end
    return acc;
  endfunction

  // Reference CHAR: x rendered as 10 decimal character codes, MSD first.
  function automatic logic [59:0] to_chars(input longint x);
    logic [59:0] v = '0;
    longint t = x;
    for (int k = 9; k >= 0; k--) begin
      v[59-6*k -: 6] = char_code(4'(t % 10));
      t = t / 10;
    end
    return v;
  endfunction

  function automatic logic [59:0] pack(input int b0, b1, b2, b3, b4, b5, b6, b7, b8, b9);
    return {6'(b0), 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5), 6'(b6), 6'(b7), 6'(b8), 6'(b9)};
  endfunction

  // Runs one job from a start pulse; checks latency, result, single stop pulse, hold.
  task automatic do_job(input string tag, input logic [59:0] v, input longint exp, input int s0);
    int lat;
    start = 1'b1;
    in_v  = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!stop && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_out"}, out_v, exp);
    @(posedge clk); #1;
    check({tag, "_stop_drop"}, stop, 0);
    check({tag, "_hold"}, out_v, exp);
    check({tag, "_stop_pulses"}, stop_seen - s0, 1);
    $display("job %s in=%015h out=%0d exp=%0d latency=%0d", tag, v, out_v, exp, lat);
  endtask

  initial begin
    int s0;
    logic [59:0] v;
    longint x;

    repeat (2) @(posedge clk);
    #1;
    check("reset_stop", stop, 0);
    check("reset_out", out_v, 0);
    reset = 1'b0;

    do_job("t1_12345", pack(30,30,30,30,30,31,32,33,34,35), 12345, stop_seen);
    do_job("t2_all9", pack(39,39,39,39,39,39,39,39,39,39), 336323583, stop_seen);
    do_job("t3_nondigit", pack(0,1,2,3,4,5,6,7,8,63), 123456783, stop_seen);
    do_job("t3_zero", '0, 0, stop_seen);

    // Restart mid-job: only the second job produces a stop.
    s0 = stop_seen;
    start = 1'b1; in_v = pack(39,39,39,39,39,39,39,39,39,39);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    do_job("t4_restart", pack(30,30,30,30,30,30,30,30,34,32), 42, s0);

    // Reset in the middle of a job: no stop, out cleared.
    s0 = stop_seen;
    start = 1'b1; in_v = pack(31,32,33,34,35,36,37,38,39,30);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_rst_out", out_v, 0);
    repeat (15) @(posedge clk);
    #1;
    check("t5_rst_nostop", stop_seen - s0, 0);
    check("t5_rst_out_late", out_v, 0);
    $display("job t5_reset_mid stops=%0d out=%0d", stop_seen - s0, out_v);

    // Start and reset together: reset wins.
    s0 = stop_seen;
    start = 1'b1; reset = 1'b1; in_v = pack(39,39,39,39,39,39,39,39,39,39);
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("t5_both_nostop", stop_seen - s0, 0);
    check("t5_both_out", out_v, 0);
    $display("job t5_start_reset stops=%0d out=%0d", stop_seen - s0, out_v);

    // Round trip through a reference CHAR conversion.
    for (int i = 0; i < 12; i++) begin
      x = longint'($urandom) & 64'h3FFF_FFFF;
      do_job($sformatf("t6_rt%0d", i), to_chars(x), x, stop_seen);
    end

    // Arbitrary byte patterns against the reference model.
    for (int i = 0; i < 12; i++) begin
      v = {$urandom, $urandom};
      do_job($sformatf("rand%0d", i), v, ref_num(v), stop_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
